clint_mh: RTL and testbench

//  Parametrised multi-hart core-local interruptor; next generation of the single-hart CLINT.

---
 rtl/clint_mh_pkg.sv | 47 ++++
 rtl/clint_mh_tick.sv | 29 ++
 rtl/clint_mh.sv | 173 +++++++++++++++++
 tb/tb_clint_mh.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_mh_pkg.sv
// Shared types and address map for the multi-hart core-local interruptor.
package clint_mh_pkg;

  localparam int unsigned CSR_TIME_W = 64;
  localparam int unsigned XLEN       = 32;

  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_CTRL_OFS      = 16'hBFF0;
  localparam logic [15:0] CLINT_MTIME_OFS     = 16'hBFF8;
  localparam int unsigned CLINT_MAX_HART      = 16;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_t;

  typedef struct packed {
    logic [XLEN-1:0]   req_addr;
    mem_type_t         req_type;
    logic [XLEN-1:0]   req_data;
    logic [XLEN/8-1:0] req_mask;
  } mem_req_t;

  typedef struct packed {
    logic [XLEN-1:0] resp_data;
    logic            resp_last;
  } mem_resp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_t;

  // Byte-masked update of a 32-bit register word.
  function automatic logic [XLEN-1:0] mask_merge(input logic [XLEN-1:0]   old_val,
                                                 input logic [XLEN-1:0]   new_val,
                                                 input logic [XLEN/8-1:0] mask);
    logic [XLEN-1:0] res;
    res = old_val;
    for (int unsigned b = 0; b < XLEN/8; b++) begin
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mh_tick.sv
// Prescaler for mtime: emits one tick every DIV+1 enabled cycles.
module clint_tick_gen #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = en && (cnt == div);

  // Prescaler counter: cleared on CTRL write, frozen while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == div) cnt <= '0;
      else            cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: shared prescaled mtime, per-hart msip/mtimecmp, mem_if slave.
module clint_mh
  import clint_mh_pkg::*;
#(
  parameter int unsigned N_HART       = 1,
  parameter int unsigned PRESCALE_W   = 8,
  parameter bit          CMP_RST_ONES = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mem_req_valid,
  output logic                  mem_req_ready,
  input  mem_req_t              mem_req,
  output logic                  mem_resp_valid,
  input  logic                  mem_resp_ready,
  output mem_resp_t             mem_resp,
  output logic [N_HART-1:0]     soft_irq,
  output logic [N_HART-1:0]     time_irq,
  output logic [CSR_TIME_W-1:0] time_val
);

  localparam logic [CSR_TIME_W-1:0] CMP_RST = {CSR_TIME_W{CMP_RST_ONES}};

  bus_state_t state, state_nxt;

  logic [15:0]           word;
  logic [N_HART-1:0]     msip_sel, cmp_lo_sel, cmp_hi_sel;
  logic                  ctrl_sel, mtime_lo_sel, mtime_hi_sel;
  logic [XLEN-1:0]       rdata, wdata, ctrl_word, resp_data;
  logic                  acc, wr, ctrl_wr, tick;

  logic [N_HART-1:0]     msip;
  logic [CSR_TIME_W-1:0] cmp [N_HART];
  logic [CSR_TIME_W-1:0] mtime;
  logic                  en;
  logic [PRESCALE_W-1:0] div;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req.req_addr[XLEN-1:16], mem_req.req_addr[1:0]};

  assign mem_req_ready  = (state == ST_IDLE);
  assign mem_resp_valid = (state == ST_RESP);
  assign acc            = mem_req_valid && mem_req_ready;
  assign wr             = acc && (mem_req.req_type == MEM_WRITE);
  assign ctrl_wr        = wr && ctrl_sel;
  assign wdata          = mask_merge(rdata, mem_req.req_data, mem_req.req_mask);

  assign mem_resp.resp_data = resp_data;
  assign mem_resp.resp_last = mem_resp_valid;
  assign soft_irq           = msip;
  assign time_val           = mtime;

  // Bus state register: one outstanding transaction at a time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Bus next-state: accept in idle, release on response handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mem_req_valid)  state_nxt = ST_RESP;
      ST_RESP: if (mem_resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address decode on word-aligned offset; one select per hart register.
  always_comb begin
    word         = {mem_req.req_addr[15:2], 2'b00};
    msip_sel     = '0;
    cmp_lo_sel   = '0;
    cmp_hi_sel   = '0;
    for (int unsigned h = 0; h < N_HART; h++) begin
      msip_sel[h]   = (word == CLINT_MSIP_BASE     + 16'(4*h));
      cmp_lo_sel[h] = (word == CLINT_MTIMECMP_BASE + 16'(8*h));
      cmp_hi_sel[h] = (word == CLINT_MTIMECMP_BASE + 16'(8*h + 4));
    end
    ctrl_sel     = (word == CLINT_CTRL_OFS);
    mtime_lo_sel = (word == CLINT_MTIME_OFS);
    mtime_hi_sel = (word == CLINT_MTIME_OFS + 16'd4);
  end

  // CTRL read view: EN in bit 0, DIV from bit 8.
  always_comb begin
    ctrl_word                 = '0;
    ctrl_word[0]              = en;
    ctrl_word[8 +: PRESCALE_W] = div;
  end

  // Read mux; unmapped offsets read zero.
  always_comb begin
    rdata = '0;
    for (int unsigned h = 0; h < N_HART; h++) begin
      if (msip_sel[h])   rdata = {{(XLEN-1){1'b0}}, msip[h]};
      if (cmp_lo_sel[h]) rdata = cmp[h][31:0];
      if (cmp_hi_sel[h]) rdata = cmp[h][63:32];
    end
    if (ctrl_sel)     rdata = ctrl_word;
    if (mtime_lo_sel) rdata = mtime[31:0];
    if (mtime_hi_sel) rdata = mtime[63:32];
  end

  // Response data captured at acceptance (value before any write).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    resp_data <= '0;
    else if (acc) resp_data <= rdata;
  end

  // Per-hart software interrupt pending bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      msip <= '0;
    end else begin
      for (int unsigned h = 0; h < N_HART; h++) begin
        if (wr && msip_sel[h]) msip[h] <= wdata[0];
      end
    end
  end

  // Per-hart timer compare registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned h = 0; h < N_HART; h++) cmp[h] <= CMP_RST;
    end else begin
      for (int unsigned h = 0; h < N_HART; h++) begin
        if (wr && cmp_lo_sel[h]) cmp[h][31:0]  <= wdata;
        if (wr && cmp_hi_sel[h]) cmp[h][63:32] <= wdata;
      end
    end
  end

  // CTRL register: enable and prescaler divisor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en  <= 1'b0;
      div <= '0;
    end else if (ctrl_wr) begin
      en  <= wdata[0];
      div <= wdata[8 +: PRESCALE_W];
    end
  end

  // mtime: bus writes take priority over the tick increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     mtime        <= '0;
    else if (wr && mtime_lo_sel)   mtime[31:0]  <= wdata;
    else if (wr && mtime_hi_sel)   mtime[63:32] <= wdata;
    else if (tick)                 mtime        <= mtime + 64'd1;
  end

  // Registered unsigned compare per hart, independent of EN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      time_irq <= '0;
    end else begin
      for (int unsigned h = 0; h < N_HART; h++) time_irq[h] <= (mtime >= cmp[h]);
    end
  end

  clint_tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick (
    .clk (clk),
    .rstn(rstn),
    .en  (en),
    .div (div),
    .clr (ctrl_wr),
    .tick(tick)
  );

endmodule

// File: tb/tb_clint_mh.sv
// Scoreboard bench for clint_mh with a cycle-level behavioural register model.
module tb_clint_mh;
  import clint_mh_pkg::*;

  localparam int NH = 4;

  logic            clk, rstn;
  logic            mem_req_valid, mem_req_ready;
  mem_req_t        mem_req;
  logic            mem_resp_valid, mem_resp_ready;
  mem_resp_t       mem_resp;
  logic [NH-1:0]   soft_irq, time_irq;
  logic [63:0]     time_val;

  int total = 0;
  int bad   = 0;
  int bp_mode = 0;   // 0: always ready, 1: random backpressure, 2: stall

  // behavioural model state
  bit          m_busy;
  logic [NH-1:0] m_msip, m_irq;
  logic [63:0] m_cmp [NH];
  logic [63:0] m_time;
  bit          m_en;
  int          m_div, m_cnt;
  logic [31:0] exp_q [$];

  clint_mh #(
    .N_HART(NH),
    .PRESCALE_W(8),
    .CMP_RST_ONES(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req(mem_req),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp(mem_resp),
    .soft_irq(soft_irq), .time_irq(time_irq), .time_val(time_val)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] off);
    int h;
    if (off < 16'h4000) begin
      h = int'(off) / 4;
      return (h < NH) ? {31'b0, m_msip[h]} : 32'h0;
    end
    if (int'(off) >= 'h4000 && int'(off) < 'h4000 + 8*NH) begin
      h = (int'(off) - 'h4000) / 8;
      return off[2] ? m_cmp[h][63:32] : m_cmp[h][31:0];
    end
    if (off == 16'hBFF0) return {16'b0, 8'(m_div), 7'b0, m_en};
    if (off == 16'hBFF8) return m_time[31:0];
    if (off == 16'hBFFC) return m_time[63:32];
    return 32'h0;
  endfunction

  // Reference model: register file, prescaler and compare evaluated once per cycle.
  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_busy = 0; m_msip = '0; m_irq = '0; m_en = 0; m_div = 0; m_cnt = 0; m_time = '0;
        for (int i = 0; i < NH; i++) m_cmp[i] = '1;
        exp_q.delete();
      end else begin
        bit tick;
        logic [63:0] tn;
        logic [31:0] rv, wv;
        logic [15:0] off;
        int h;
        tick = m_en && (m_cnt == m_div);
        tn = tick ? m_time + 64'd1 : m_time;
        for (int i = 0; i < NH; i++) m_irq[i] = (m_time >= m_cmp[i]);
        if (tick) m_cnt = 0; else if (m_en) m_cnt = m_cnt + 1;
        if (mem_req_valid && !m_busy) begin
          off = {mem_req.req_addr[15:2], 2'b00};
          rv = model_read(off);
          exp_q.push_back(rv);
          m_busy = 1;
          if (mem_req.req_type == MEM_WRITE) begin
            wv = merge_bytes(rv, mem_req.req_data, mem_req.req_mask);
            if (off == 16'hBFF0) begin
              m_en = wv[0]; m_div = int'(wv[15:8]); m_cnt = 0;
            end else if (off == 16'hBFF8) tn = {m_time[63:32], wv};
            else if (off == 16'hBFFC) tn = {wv, m_time[31:0]};
            else if (off < 16'h4000) begin
              if (int'(off) / 4 < NH) m_msip[int'(off) / 4] = wv[0];
            end else if (int'(off) >= 'h4000 && int'(off) < 'h4000 + 8*NH) begin
              h = (int'(off) - 'h4000) / 8;
              if (off[2]) m_cmp[h][63:32] = wv; else m_cmp[h][31:0] = wv;
            end
          end
        end else if (m_busy && mem_resp_ready) begin
          m_busy = 0;
        end
        m_time = tn;
      end
    end
  end

  // Monitor: compares DUT outputs to the model and pops responses on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("req_ready", mem_req_ready, m_busy ? 0 : 1);
        chk("resp_valid", mem_resp_valid, m_busy ? 1 : 0);
        chk("time_val", time_val, m_time);
        chk("time_irq", time_irq, m_irq);
        chk("soft_irq", soft_irq, m_msip);
        if (mem_resp_valid && mem_resp_ready) begin
          if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
          else begin
            chk("resp_data", mem_resp.resp_data, exp_q.pop_front());
            chk("resp_last", mem_resp.resp_last, 1);
          end
        end
      end
    end
  end

  // Response-ready driver.
  initial begin
    mem_resp_ready = 1;
    forever begin
      @(posedge clk);
      #2;
      mem_resp_ready = (bp_mode == 2) ? 1'b0 : (bp_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic set_req(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] m);
    mem_req.req_addr = a;
    mem_req.req_type = w ? MEM_WRITE : MEM_READ;
    mem_req.req_data = d;
    mem_req.req_mask = m;
    mem_req_valid    = 1;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    int n = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = mem_req_ready;
      @(posedge clk);
      n++;
    end
    chk("req_accept_timeout", ok, 1);
  endtask

  task automatic wait_resp(output logic [31:0] d);
    bit ok = 0;
    int n = 0;
    d = '0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (mem_resp_valid && mem_resp_ready) begin
        ok = 1;
        d = mem_resp.resp_data;
      end
      n++;
    end
    chk("resp_timeout", ok, 1);
  endtask

  task automatic bus(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] m,
                     output logic [31:0] rd);
    @(posedge clk);
    #1;
    set_req(a, w, d, m);
    wait_accept();
    #1 mem_req_valid = 0;
    wait_resp(rd);
  endtask

  logic [31:0] rd, d0;
  logic [15:0] offs [16] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0040,
                              16'h4000, 16'h4004, 16'h4008, 16'h400C, 16'h4018, 16'h401C,
                              16'h4020, 16'hBFF0, 16'hBFF8, 16'hBFFC};

  initial begin
    rstn = 0;
    mem_req_valid = 0;
    mem_req = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;

    // reset state and compare defaults
    bus(32'h4000, 0, 0, 0, rd); chk("rst_cmp0_lo", rd, 32'hFFFF_FFFF);
    bus(32'h4004, 0, 0, 0, rd); chk("rst_cmp0_hi", rd, 32'hFFFF_FFFF);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("rst_irq_quiet", time_irq, 0);
    chk("rst_req_ready", mem_req_ready, 1);

    // prescaler rate: DIV=3 -> one increment per 4 cycles
    bus(32'hBFF0, 1, 32'h0000_0301, 4'hF, rd);
    repeat (40) @(posedge clk);
    bus(32'hBFF8, 0, 0, 0, rd);
    chk("mtime_div3", rd, 10);

    // hart 2 timer interrupt
    bus(32'hBFF0, 1, 0, 4'hF, rd);
    bus(32'hBFF8, 1, 0, 4'hF, rd);
    bus(32'hBFFC, 1, 0, 4'hF, rd);
    bus(32'h4010, 1, 20, 4'hF, rd);
    bus(32'h4014, 1, 0, 4'hF, rd);
    bus(32'hBFF0, 1, 1, 4'hF, rd);
    begin
      int n = 0;
      while (time_irq == 0 && n < 200) begin @(negedge clk); n++; end
      chk("irq_h2_vec", time_irq, 4'b0100);
      chk("irq_h2_time", time_val, 21);
    end

    // carry lo->hi and 64-bit wrap
    bus(32'hBFF0, 1, 0, 4'hF, rd);
    bus(32'hBFF8, 1, 32'hFFFF_FFFF, 4'hF, rd);
    bus(32'hBFFC, 1, 0, 4'hF, rd);
    bus(32'hBFF0, 1, 1, 4'hF, rd);
    bus(32'hBFFC, 0, 0, 0, rd); chk("carry_hi", rd, 1);
    bus(32'hBFF0, 1, 0, 4'hF, rd);
    bus(32'hBFF8, 1, 32'hFFFF_FFFF, 4'hF, rd);
    bus(32'hBFFC, 1, 32'hFFFF_FFFF, 4'hF, rd);
    bus(32'hBFF0, 1, 1, 4'hF, rd);
    bus(32'hBFFC, 0, 0, 0, rd); chk("wrap_hi", rd, 0);
    bus(32'hBFF0, 1, 0, 4'hF, rd);

    // response stall: read msip[1], hold ready low with a second request waiting
    bp_mode = 2;
    @(posedge clk); @(posedge clk);
    #1 set_req(32'h0004, 0, 0, 0);
    wait_accept();
    #1 mem_req_valid = 0;
    @(negedge clk);
    d0 = mem_resp.resp_data;
    chk("stall_rd_msip1", d0, 0);
    set_req(32'h0004, 1, 1, 4'h1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_ready", mem_req_ready, 0);
      chk("stall_resp_valid", mem_resp_valid, 1);
      chk("stall_resp_hold", mem_resp.resp_data, d0);
    end
    bp_mode = 0;
    wait_accept();
    #1 mem_req_valid = 0;
    wait_resp(rd);
    @(negedge clk);
    chk("stall_msip1_set", soft_irq[1], 1);

    // byte masks and out-of-range hart
    bus(32'h000C, 1, 1, 4'h0, rd);
    @(negedge clk); chk("msip3_mask0", soft_irq[3], 0);
    bus(32'h000C, 1, 1, 4'h1, rd);
    @(negedge clk); chk("msip3_mask1", soft_irq[3], 1);
    bus(32'h0040, 1, 32'hFFFF_FFFF, 4'hF, rd);
    bus(32'h0040, 0, 0, 0, rd); chk("msip16_reads0", rd, 0);

    // randomized traffic with backpressure
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = {16'($urandom), offs[$urandom_range(0, 15)]};
      if ($urandom_range(0, 7) == 0) a = $urandom;
      d = $urandom;
      if (a[15:0] == 16'hBFF0) d[15:8] = 8'($urandom_range(0, 3));
      bus(a, $urandom_range(0, 1) == 1, d, 4'($urandom), rd);
    end

    // reset while a response is pending
    bp_mode = 2;
    @(posedge clk); @(posedge clk);
    #1 set_req(32'hBFF8, 0, 0, 0);
    wait_accept();
    #1 mem_req_valid = 0;
    @(posedge clk);
    #1 rstn = 0;
    #3 rstn = 1;
    bp_mode = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_resp", mem_resp_valid, 0);
    end
    chk("post_rst_time", time_val, 0);
    chk("post_rst_soft", soft_irq, 0);
    bus(32'h4018, 0, 0, 0, rd); chk("post_rst_cmp3_lo", rd, 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
